rob_dispatch_unit: RTL

- Instruction handler front end for the reorder buffer. Buffers incoming decoded-width instructions in a small queue.
- Classifies each instruction as LS, ADD or MULT, then allocates the next in-order ROB entry and the lowest free reservation station of that class.
- Drives index_rb, index_rs and instruction into the ROB top; stalls on ROB-entry or RS structural hazards.

---
 rtl/dispatch_pkg.sv | 33 +++
 rtl/dispatch_fifo.sv | 67 ++++++
 rtl/rob_dispatch_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared types for the ROB dispatch front end: instruction classes, opcodes and RS id ranges.
package dispatch_pkg;

   typedef enum logic [1:0] {CL_LS, CL_ADD, CL_MULT, CL_ILLEGAL} instr_class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [3:0] LS_FIRST   = 4'd1;
   localparam logic [3:0] LS_LAST    = 4'd6;
   localparam logic [3:0] ADD_FIRST  = 4'd7;
   localparam logic [3:0] ADD_LAST   = 4'd9;
   localparam logic [3:0] MULT_FIRST = 4'd10;
   localparam logic [3:0] MULT_LAST  = 4'd11;

   localparam int NUM_RS  = 12;
   localparam int NUM_ROB = 8;

   function automatic instr_class_e classify(input logic [6:0] opcode, input logic [6:0] funct7);
      instr_class_e cl;
      case (opcode)
         OPC_LOAD, OPC_STORE: cl = CL_LS;
         OPC_OP:              cl = (funct7 == F7_MULDIV) ? CL_MULT : CL_ADD;
         OPC_OP_IMM:          cl = CL_ADD;
         default:             cl = CL_ILLEGAL;
      endcase
      return cl;
   endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; head word visible combinationally, one-cycle write-to-head.
// Caller must not push when full without popping, nor pop when empty.
module dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wptr_q] = push_dat;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the pointers decide what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_dat = mem_q[rptr_q];
   assign count    = count_q;
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/rob_dispatch_unit.sv
// ROB dispatch front end: queues instructions, classifies the head, allocates an in-order ROB entry
// and the lowest free RS of its class. Outputs registered one cycle after the head is seen; stalls on hazards.
module rob_dispatch_unit
   import dispatch_pkg::*;
#(
   parameter int QDEPTH         = 4,
   parameter int ROB_RESET_TAIL = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [31:0]               in_instr,
   output logic                      in_ready,
   input  logic [7:0]                rob_busy,
   input  logic [11:0]               rs_busy,
   output logic [2:0]                index_rb,
   output logic [3:0]                index_rs,
   output logic [31:0]               instruction,
   output logic                      dispatch_valid,
   output logic                      stall_struct,
   output logic [$clog2(QDEPTH):0]   q_count
);

   localparam logic [2:0] TAIL_RST = 3'(ROB_RESET_TAIL);

   logic [31:0]   head_dat;
   logic          q_full, q_empty;
   logic          push, pop, fire, legal;
   instr_class_e  head_cl;
   logic [3:0]    rs_first, rs_last, rs_pick;
   logic          rs_found, rob_free;

   logic [2:0]    tail_q, tail_d;
   logic [11:0]   pend_rs_q, pend_rs_d;
   logic [7:0]    pend_rb_q, pend_rb_d;
   logic [2:0]    index_rb_q, index_rb_d;
   logic [3:0]    index_rs_q, index_rs_d;
   logic [31:0]   instruction_q, instruction_d;
   logic          dispatch_valid_q, dispatch_valid_d;
   logic          stall_struct_q, stall_struct_d;

   dispatch_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (in_instr),
      .pop      (pop),
      .head_dat (head_dat),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

   always_comb begin
      head_cl = classify(head_dat[6:0], head_dat[31:25]);
      case (head_cl)
         CL_LS:   begin rs_first = LS_FIRST;   rs_last = LS_LAST;   end
         CL_ADD:  begin rs_first = ADD_FIRST;  rs_last = ADD_LAST;  end
         CL_MULT: begin rs_first = MULT_FIRST; rs_last = MULT_LAST; end
         default: begin rs_first = 4'd15;      rs_last = 4'd0;      end
      endcase

      // Scan downward so the last hit is the lowest free id; pend_rs covers the busy-report lag.
      rs_pick  = 4'd0;
      rs_found = 1'b0;
      for (int n = NUM_RS - 1; n >= 0; n--) begin
         if (4'(n) >= rs_first && 4'(n) <= rs_last && !rs_busy[n] && !pend_rs_q[n]) begin
            rs_pick  = 4'(n);
            rs_found = 1'b1;
         end
      end

      rob_free = !rob_busy[tail_q] && !pend_rb_q[tail_q];
      legal    = !q_empty && (head_cl != CL_ILLEGAL);
      fire     = legal && rs_found && rob_free;
      pop      = fire || (!q_empty && (head_cl == CL_ILLEGAL));
   end

   assign in_ready = !q_full || fire;
   assign push     = in_valid && in_ready;

   always_comb begin
      tail_d           = fire ? tail_q + 3'd1 : tail_q;
      pend_rs_d        = fire ? (12'd1 << rs_pick) : 12'd0;
      pend_rb_d        = fire ? (8'd1 << tail_q) : 8'd0;
      index_rb_d       = fire ? tail_q : index_rb_q;
      index_rs_d       = fire ? rs_pick : 4'd0;
      instruction_d    = fire ? head_dat : 32'd0;
      dispatch_valid_d = fire;
      stall_struct_d   = legal && !fire;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tail_q           <= TAIL_RST;
         pend_rs_q        <= '0;
         pend_rb_q        <= '0;
         index_rb_q       <= TAIL_RST;
         index_rs_q       <= '0;
         instruction_q    <= '0;
         dispatch_valid_q <= 1'b0;
         stall_struct_q   <= 1'b0;
      end else begin
         tail_q           <= tail_d;
         pend_rs_q        <= pend_rs_d;
         pend_rb_q        <= pend_rb_d;
         index_rb_q       <= index_rb_d;
         index_rs_q       <= index_rs_d;
         instruction_q    <= instruction_d;
         dispatch_valid_q <= dispatch_valid_d;
         stall_struct_q   <= stall_struct_d;
      end
   end

   assign index_rb       = index_rb_q;
   assign index_rs       = index_rs_q;
   assign instruction    = instruction_q;
   assign dispatch_valid = dispatch_valid_q;
   assign stall_struct   = stall_struct_q;

endmodule
